// File: rtl/my_fifo_pkg.sv
// my_fifo_pkg: shared defaults and a constant-evaluable clog2 for the FIFO blocks
package my_fifo_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int DEPTH_DEF  = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/my_fifo_mem.sv
// my_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// Kept separate so an SRAM macro with the same port shape can replace it.
module my_fifo_mem #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/my_sync_fifo.sv
// my_sync_fifo: parametrised show-ahead synchronous FIFO with thresholds and sticky errors
// Ports: clk, rst (sync, active-high); wr_en/wr_data write side; rd_en/rd_data show-ahead head word;
// full/empty/almost_full/almost_empty/count registered status; overflow/underflow sticky, cleared by err_clr.
// Build option MY_FIFO_PEAK_EN adds output peak: max count since reset or err_clr.
module my_sync_fifo
  import my_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  localparam int ADDR_W   = clog2(DEPTH),
  localparam int CNT_W    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
`ifdef MY_FIFO_PEAK_EN
  ,
  output logic [CNT_W-1:0]  peak
`endif
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic wr_acc, rd_acc;
  // a write into a full FIFO is still accepted when a read frees a slot the same cycle
  always_comb begin
    wr_acc      = wr_en & (~full | rd_en);
    rd_acc      = rd_en & ~empty;
    count_next  = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    wr_ptr_next = (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
    rd_ptr_next = (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_W'(1);
  end
  // flags come from count_next so they move on the same edge as count
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_acc ? wr_ptr_next : wr_ptr;
      rd_ptr       <= rd_acc ? rd_ptr_next : rd_ptr;
      count        <= count_next;
      empty        <= count_next == '0;
      full         <= count_next == CNT_W'(DEPTH);
      almost_empty <= count_next <= CNT_W'(AEMPTY_TH);
      almost_full  <= count_next >= CNT_W'(AFULL_TH);
      overflow     <= (wr_en & full & ~rd_en) | (overflow & ~err_clr);
      underflow    <= (rd_en & empty) | (underflow & ~err_clr);
    end
`ifdef MY_FIFO_PEAK_EN
  always_ff @(posedge clk)
    if (rst) peak <= '0;
    else peak <= (err_clr || count_next > peak) ? count_next : peak;
`endif
  my_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_my_sync_fifo.sv
// tb_my_sync_fifo: randomized scoreboard bench for my_sync_fifo against a queue-based model
module tb_my_sync_fifo;
  localparam int DW = 12, DP = 6, AF = 5, AE = 1, CW = 3;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;
`ifdef MY_FIFO_PEAK_EN
  logic [CW-1:0] peak;
`endif
  int tests = 0, fails = 0;
  bit armed = 0;
  logic [DW-1:0] mq[$];
  bit m_ov, m_un, m_f, m_e, m_wa, m_ra;
  int m_peak, n_m;

  my_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`ifdef MY_FIFO_PEAK_EN
    , .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: occupancy is the queue itself, flags follow from its size
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ov = 0;
      m_un = 0;
      m_peak = 0;
    end else begin
      m_f  = mq.size() == DP;
      m_e  = mq.size() == 0;
      m_ra = rd_en && !m_e;
      m_wa = wr_en && (!m_f || rd_en);
      m_ov = (wr_en && m_f && !rd_en) || (m_ov && !err_clr);
      m_un = (rd_en && m_e) || (m_un && !err_clr);
      if (m_ra) void'(mq.pop_front());
      if (m_wa) mq.push_back(wr_data);
      m_peak = (err_clr || mq.size() > m_peak) ? mq.size() : m_peak;
    end
  end

  // monitor: compare DUT outputs with the model away from the active edge
  always @(negedge clk) if (armed) begin
    n_m = mq.size();
    chk("count", 32'(count), n_m);
    chk("empty", 32'(empty), 32'(n_m == 0));
    chk("full", 32'(full), 32'(n_m == DP));
    chk("almost_full", 32'(almost_full), 32'(n_m >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n_m <= AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
    if (n_m > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`ifdef MY_FIFO_PEAK_EN
    chk("peak", 32'(peak), m_peak);
`endif
  end

  task automatic step(input bit r, input bit we, input logic [DW-1:0] d, input bit re, input bit ec);
    @(negedge clk);
    rst = r; wr_en = we; wr_data = d; rd_en = re; err_clr = ec;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1;
    idle();
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    for (int i = 1; i <= DP; i++) step(0, 1, DW'(i), 0, 0);
    idle();
    chk("fill_count", 32'(count), 6);
    chk("fill_full", 32'(full), 1);
    chk("fill_head", 32'(rd_data), 32'h001);
    step(0, 1, 12'h0AA, 0, 0);
    idle();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 6);
    step(0, 0, '0, 0, 1);
    idle();
    chk("ovf_clr", 32'(overflow), 0);
    step(0, 1, 12'h0BB, 1, 0);
    idle();
    chk("both_full_count", 32'(count), 6);
    chk("both_full_head", 32'(rd_data), 32'h002);
    for (int i = 0; i < DP; i++) step(0, 0, '0, 1, 0);
    idle();
    chk("drained_empty", 32'(empty), 1);
    step(0, 1, 12'h123, 1, 0);
    idle();
    chk("both_empty_count", 32'(count), 1);
    chk("both_empty_unf", 32'(underflow), 1);
    chk("both_empty_data", 32'(rd_data), 32'h123);
    step(0, 0, '0, 1, 1);
    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = (i < 100) ? 70 : (i < 200) ? 30 : 50;
      step(0, $urandom_range(99) < wp, DW'($urandom), $urandom_range(99) >= wp, $urandom_range(99) < 5);
    end
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, DW'($urandom), 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 1, 12'h5A5, 0, 0);
    idle();
    chk("pre_rst_count", 32'(count), 4);
    step(1, 1, 12'h777, 1, 0);
    idle();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_aempty", 32'(almost_empty), 1);
    chk("mid_rst_unf", 32'(underflow), 0);
`ifdef MY_FIFO_PEAK_EN
    chk("mid_rst_peak", 32'(peak), 0);
`endif
    for (int i = 0; i < 100; i++)
      step(0, $urandom_range(1) == 1, DW'($urandom), $urandom_range(1) == 1, 0);
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
